// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator.
package pwm_pkg;

  // Counting mode of the shared timebase.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Count direction, only meaningful in center-aligned mode.
  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } pwm_dir_e;

  // Default width of counter, period and duty values.
  parameter int unsigned DutyWidth = 8;
  typedef logic [DutyWidth-1:0] duty_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: counter, direction and period-boundary detection.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_restart,
  input  pwm_mode_e             i_mode,
  input  logic [RESOLUTION-1:0] i_period,
  output logic [RESOLUTION-1:0] o_cnt,
  output logic                  o_boundary
);

  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  pwm_dir_e              dir_q, dir_d;
  logic                  boundary;

  // Boundary: last cycle of the current period for the active mode.
  always_comb begin
    boundary = 1'b0;
    if (i_period == '0) begin
      boundary = 1'b1;
    end else if (i_mode == PWM_EDGE) begin
      boundary = (cnt_q == i_period);
    end else begin
      boundary = (dir_q == DirDown) && (cnt_q == '0);
    end
  end

  // Next counter/direction; center mode repeats the turning values once.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!i_en || i_restart || (i_period == '0)) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (i_mode == PWM_EDGE) begin
      dir_d = DirUp;
      if (cnt_q >= i_period) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dir_q == DirUp) begin
      if (cnt_q >= (i_period - 1'b1)) begin
        dir_d = DirDown;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == '0) begin
        dir_d = DirUp;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter and direction state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      dir_q <= DirUp;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_boundary = boundary;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shadowed period/duty/mode settings over one shared timebase.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_load,
  input  logic [RESOLUTION-1:0]          i_period,
  input  logic [CHANNELS*RESOLUTION-1:0] i_duty,
  input  logic                           i_center,
  output logic [CHANNELS-1:0]            o_pwm,
  output logic                           o_period_done,
  output logic                           o_load_ack
);

  // Pending (shadow) set.
  logic [RESOLUTION-1:0]          pend_period_q, pend_period_d;
  logic [CHANNELS*RESOLUTION-1:0] pend_duty_q, pend_duty_d;
  pwm_mode_e                      pend_mode_q, pend_mode_d;
  logic                           pend_flag_q, pend_flag_d;

  // Active set.
  logic [RESOLUTION-1:0]          act_period_q, act_period_d;
  logic [CHANNELS*RESOLUTION-1:0] act_duty_q, act_duty_d;
  pwm_mode_e                      act_mode_q, act_mode_d;

  // Registered outputs.
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;

  logic [RESOLUTION-1:0] cnt;
  logic                  boundary;
  logic                  apply;

  // Pending settings transfer at a boundary, or immediately while disabled.
  assign apply = pend_flag_q && (boundary || !i_en);

  pwm_timebase #(
    .RESOLUTION (RESOLUTION)
  ) u_timebase (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_restart  (apply),
    .i_mode     (act_mode_q),
    .i_period   (act_period_q),
    .o_cnt      (cnt),
    .o_boundary (boundary)
  );

  // Per-channel comparators against the active duty values.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign pwm_d[k] = i_en && (cnt < act_duty_q[k*RESOLUTION +: RESOLUTION]);
  end

  // Shadow/active register updates; a load coincident with an apply waits a period.
  always_comb begin
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_mode_d   = pend_mode_q;
    pend_flag_d   = pend_flag_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    act_mode_d    = act_mode_q;
    if (apply) begin
      act_period_d = pend_period_q;
      act_duty_d   = pend_duty_q;
      act_mode_d   = pend_mode_q;
      pend_flag_d  = 1'b0;
    end
    if (i_load) begin
      pend_period_d = i_period;
      pend_duty_d   = i_duty;
      pend_mode_d   = pwm_mode_e'(i_center);
      pend_flag_d   = 1'b1;
    end
  end

  // Status outputs for the next cycle.
  always_comb begin
    done_d = i_en && boundary;
    ack_d  = apply;
  end

  // Settings and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_mode_q   <= PWM_EDGE;
      pend_flag_q   <= 1'b0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      act_mode_q    <= PWM_EDGE;
      pwm_q         <= '0;
      done_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_mode_q   <= pend_mode_d;
      pend_flag_q   <= pend_flag_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      act_mode_q    <= act_mode_d;
      pwm_q         <= pwm_d;
      done_q        <= done_d;
      ack_q         <= ack_d;
    end
  end

  assign o_pwm         = pwm_q;
  assign o_period_done = done_q;
  assign o_load_ack    = ack_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch at RESOLUTION=4, CHANNELS=2.
module tb_pwm_multi_ch;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic       i_load;
  logic       i_center;
  logic [3:0] i_period;
  logic [7:0] i_duty;
  logic [1:0] o_pwm;
  logic       o_period_done;
  logic       o_load_ack;

  int n_checks = 0;
  int n_pass   = 0;

  int hi0, hi0a, hi1, dn, ak, ak_pos, dn_first, n01;
  logic [39:0] v0;

  always #5 i_clk = ~i_clk;

  pwm_multi_ch #(
    .RESOLUTION (4),
    .CHANNELS   (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_load        (i_load),
    .i_period      (i_period),
    .i_duty        (i_duty),
    .i_center      (i_center),
    .o_pwm         (o_pwm),
    .o_period_done (o_period_done),
    .o_load_ack    (o_load_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] p, input logic [3:0] d0, input logic [3:0] d1,
                         input logic c);
    i_period = p;
    i_duty   = {d1, d0};
    i_center = c;
  endtask

  task automatic clr_counts();
    hi0 = 0; hi0a = 0; hi1 = 0; dn = 0; ak = 0; ak_pos = -1; dn_first = -1; n01 = 0;
  endtask

  initial begin
    i_rst  = 1'b1;
    i_en   = 1'b0;
    i_load = 1'b0;
    set_cfg(4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    check_eq("rst_pwm", 32'(o_pwm), 32'd0);
    check_eq("rst_done", 32'(o_period_done), 32'd0);
    check_eq("rst_ack", 32'(o_load_ack), 32'd0);
    step();
    step();
    i_rst = 1'b0;

    // Edge mode P=9, D0=3, D1=10 loaded while disabled.
    set_cfg(4'd9, 4'd3, 4'd10, 1'b0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    check_eq("s1_ack_capture", 32'(o_load_ack), 32'd0);
    step();
    check_eq("s1_ack_dis", 32'(o_load_ack), 32'd1);
    check_eq("s1_pwm_dis", 32'(o_pwm), 32'd0);
    i_en = 1'b1;
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check_eq("s1_first_pwm", 32'(o_pwm), 32'd3);
      hi0 += int'(o_pwm[0]);
      hi1 += int'(o_pwm[1]);
      dn  += int'(o_period_done);
      if (o_period_done && dn_first < 0) dn_first = i;
    end
    check_eq("s1_hi0", 32'(hi0), 32'd6);
    check_eq("s1_hi1", 32'(hi1), 32'd20);
    check_eq("s1_done_cnt", 32'(dn), 32'd2);
    check_eq("s1_done_pos", 32'(dn_first), 32'd9);

    // Mid-period loads at cnt=4 (D0=5) then cnt=6 (D0=7); only the last applies.
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        set_cfg(4'd9, 4'd5, 4'd10, 1'b0);
        i_load = 1'b1;
      end else if (i == 6) begin
        set_cfg(4'd9, 4'd7, 4'd10, 1'b0);
        i_load = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      step();
      hi0 += int'(o_pwm[0]);
      if (i < 10) hi0a += int'(o_pwm[0]);
      dn  += int'(o_period_done);
      ak  += int'(o_load_ack);
      if (o_load_ack) ak_pos = i;
    end
    check_eq("s3_hi0_old", 32'(hi0a), 32'd3);
    check_eq("s3_hi0_total", 32'(hi0), 32'd10);
    check_eq("s3_ack_cnt", 32'(ak), 32'd1);
    check_eq("s3_ack_pos", 32'(ak_pos), 32'd9);
    check_eq("s3_done_cnt", 32'(dn), 32'd2);

    // Load coincident with a boundary lands one full period later.
    clr_counts();
    for (int i = 0; i < 30; i++) begin
      if (i == 9) begin
        set_cfg(4'd9, 4'd2, 4'd10, 1'b0);
        i_load = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      step();
      hi0 += int'(o_pwm[0]);
      ak  += int'(o_load_ack);
      if (o_load_ack) ak_pos = i;
    end
    check_eq("s4_hi0", 32'(hi0), 32'd16);
    check_eq("s4_ack_cnt", 32'(ak), 32'd1);
    check_eq("s4_ack_pos", 32'(ak_pos), 32'd19);

    // Switch to center mode P=5, D0=2, D1=0.
    clr_counts();
    v0 = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        set_cfg(4'd5, 4'd2, 4'd0, 1'b1);
        i_load = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      step();
      v0[i] = o_pwm[0];
      hi0 += int'(o_pwm[0]);
      hi1 += int'(o_pwm[1]);
      dn  += int'(o_period_done);
      if (o_load_ack) ak_pos = i;
    end
    check_eq("s2_ack_pos", 32'(ak_pos), 32'd9);
    check_eq("s2_hi0", 32'(hi0), 32'd14);
    check_eq("s2_hi1", 32'(hi1), 32'd10);
    check_eq("s2_done_cnt", 32'(dn), 32'd4);
    check_eq("s2_shape", 32'(v0[19:10]), 32'h303);

    // P=0: D0=1, D1=0 gives constant 2'b01 and a boundary every cycle.
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        set_cfg(4'd0, 4'd1, 4'd0, 1'b0);
        i_load = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      step();
      if (o_load_ack) ak_pos = i;
      if (i >= 10) begin
        n01 += int'(o_pwm == 2'b01);
        dn  += int'(o_period_done);
      end
    end
    check_eq("s5_ack_pos", 32'(ak_pos), 32'd9);
    check_eq("s5_pwm01", 32'(n01), 32'd10);
    check_eq("s5_done_cnt", 32'(dn), 32'd10);

    // Mid-period asynchronous reset, then a load while disabled.
    set_cfg(4'd9, 4'd3, 4'd10, 1'b0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    step();
    check_eq("s6_ack_p0", 32'(o_load_ack), 32'd1);
    step();
    step();
    step();
    check_eq("s6_pre_rst_pwm", 32'(o_pwm), 32'd3);
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("s6_rst_pwm", 32'(o_pwm), 32'd0);
    check_eq("s6_rst_done", 32'(o_period_done), 32'd0);
    check_eq("s6_rst_ack", 32'(o_load_ack), 32'd0);
    i_en   = 1'b0;
    i_load = 1'b1;
    set_cfg(4'd9, 4'd4, 4'd0, 1'b0);
    step();
    check_eq("s6_rst_hold_ack", 32'(o_load_ack), 32'd0);
    i_rst = 1'b0;
    step();
    check_eq("s6_capture_ack", 32'(o_load_ack), 32'd0);
    i_load = 1'b0;
    step();
    check_eq("s6_dis_ack", 32'(o_load_ack), 32'd1);
    check_eq("s6_dis_pwm", 32'(o_pwm), 32'd0);
    step();
    check_eq("s6_ack_once", 32'(o_load_ack), 32'd0);
    i_en = 1'b1;
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) check_eq("s6_first_pwm", 32'(o_pwm), 32'd1);
      hi0 += int'(o_pwm[0]);
      hi1 += int'(o_pwm[1]);
      if (o_period_done && dn_first < 0) dn_first = i;
    end
    check_eq("s6_hi0", 32'(hi0), 32'd4);
    check_eq("s6_hi1", 32'(hi1), 32'd0);
    check_eq("s6_done_pos", 32'(dn_first), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
